hc194_seq_ctrl: RTL and testbench
=================================

Name: hc194_seq_ctrl

Overview:
Command sequencer for one external 4-bit universal shift register (194-style: S1/S0 modes hold/shift-right/shift-left/load, serial inputs DSR/DSL, parallel D0..D3, active-low clear). It accepts a command with a Start/Busy handshake. For each command it drives the register's mode, data and clear pins through a load, shift and capture sequence. It returns the final register contents with a one-cycle Done pulse. It sits between a host FSM and the register so the host never toggles S1/S0 directly.

Parameters:
CNT_W, 3, width of shift-count field; max steps per command = 2^CNT_W-1

Ports:
Clk  in  1  clock; all state changes on rising edge
MR  in  1  reset, synchronous, active-high
Start  in  1  command strobe; accepted only when Busy=0
Cmd  in  2  00 load-only, 01 load+shift right, 10 load+shift left, 11 clear
Count  in  CNT_W  number of shift steps for Cmd 01/10
Din  in  4  parallel load value; Din[i] drives Di
SerIn  in  1  fill bit for non-rotate shifts
Rot  in  1  1 = rotate (fill from opposite end) instead of SerIn
Q  in  4  register outputs; Q[i] = Qi
S1, S0  out  1 each  register mode pins
DSR, DSL  out  1 each  register serial inputs
Dpar  out  4  to D0..D3
RegMR_n  out  1  register clear, active-low
Busy  out  1  command in progress
Done  out  1  one-cycle completion pulse
Dout  out  4  captured Q, valid while Done=1 and held until next capture

Behaviour:
- States: IDLE, LOAD, CLEAR, SHIFT, CAPTURE.
- Reset (MR=1 at edge): state=IDLE, Busy=0, Done=0, Dout=0, step counter=0, latched command regs=0.
- RegMR_n=0 combinationally while MR=1, which also clears the register. RegMR_n=1 otherwise, except in CLEAR.
- MR overrides everything, including mid-command. There is no partial Done.
- IDLE: S1S0=00 (hold), Busy=0.
- Start=1 in IDLE: latch Cmd, Count, Din, SerIn and Rot. Next state is LOAD, or CLEAR when Cmd=11. Busy=1 from the next cycle.
- Start while Busy=1 is ignored. It is not queued.
- LOAD (1 cycle): S1S0=11, Dpar=latched Din. Next state:
  - CAPTURE if Cmd=00 or Count=0;
  - otherwise SHIFT, with counter = Count.
- CLEAR (1 cycle): RegMR_n=0, S1S0=00. Next state is CAPTURE.
- SHIFT: S1S0=01 for Cmd 01 (Q0<-DSR, Qi<-Qi-1), or S1S0=10 for Cmd 10 (Q3<-DSL, Qi<-Qi+1).
  - Counter decrements each cycle; the state exits to CAPTURE in the cycle the counter is 1.
  - Exactly Count shift edges occur.
- Serial inputs in SHIFT:
  - DSR = Rot ? Q[3] : SerIn;
  - DSL = Rot ? Q[0] : SerIn.
  - Both are combinational from Q. Outside SHIFT, DSR=DSL=0.
- Dpar=0 outside LOAD.
- CAPTURE (1 cycle): S1S0=00. Dout<=Q and Done<=1 (both registered). Next state is IDLE.
- Done is high for exactly the first IDLE cycle after CAPTURE. Busy=0 in that cycle.
- A Start in the same cycle as Done is accepted.
- Latency from the Start edge to Done high:
  - Cmd 00, or Count=0: 3 cycles;
  - Cmd 01/10: 3+Count cycles;
  - Cmd 11: 3 cycles, with Dout=0000.
- Outputs S1/S0/Dpar/RegMR_n/Busy are Moore decodes of state and latched regs. There are no glitching paths from Start.

Test Plan:
1. MR=1 for 2 cycles mid-SHIFT (Cmd=01, Count=7) -> RegMR_n=0 during MR; after release state=IDLE, Busy=0, Done=0, Dout=0000, S1S0=00; no Done pulse.
2. Cmd=00, Din=4'b1011 -> LOAD cycle with S1S0=11 and Dpar=1011; Done 3 cycles after Start with Dout=4'b1011.
3. Cmd=01, Din=4'b1011, Count=1, SerIn=0, Rot=0 -> one S1S0=01 cycle; Dout=4'b0110 at Start+4.
4. Cmd=10, Din=4'b1011, Count=1, Rot=1 -> Dout=4'b1101.
5. Cmd=01, Din=4'b1011, Count=4, Rot=1 -> Dout=4'b1011 at Start+7.
6. Cmd=01, Din=0000, Count=3, SerIn=1 -> Dout=4'b0111 at Start+6.
7. Handshake: Start pulsed during Busy -> ignored, with exactly one Done.
8. Cmd=11 after a load of 1111 -> RegMR_n low for 1 cycle, Dout=0000.
9. Count=0 with Cmd=01 -> behaves as load-only (Done at Start+3).

Source files
------------

// File: rtl/hc194_seq_ctrl_if.sv
// Host-side command/response bundle for the 194 shift-register sequencer.
// Start/Busy handshake: a command is accepted on a rising Clk edge where
// Start=1 and Busy=0; Start while Busy=1 is dropped, never queued. The result
// appears on Dout with a one-cycle Done pulse and Dout holds until the next
// capture.
interface hc194_seq_ctrl_if #(
   parameter int CNT_W = 3
) ();
   logic             Start;
   logic [1:0]       Cmd;
   logic [CNT_W-1:0] Count;
   logic [3:0]       Din;
   logic             SerIn;
   logic             Rot;
   logic             Busy;
   logic             Done;
   logic [3:0]       Dout;

   modport master (
      output Start, Cmd, Count, Din, SerIn, Rot,
      input  Busy, Done, Dout
   );

   modport slave (
      input  Start, Cmd, Count, Din, SerIn, Rot,
      output Busy, Done, Dout
   );
endinterface

// File: rtl/hc194_seq_ctrl.sv
// Sequencer for one external 194-style 4-bit universal shift register:
// load, optional shift/rotate, capture, with a Start/Busy/Done handshake.
module hc194_seq_ctrl #(
   parameter int CNT_W = 3
) (
   input  logic             Clk,
   input  logic             MR,
   hc194_seq_ctrl_if.slave  host,
   input  logic [3:0]       Q,
   output logic             S1,
   output logic             S0,
   output logic             DSR,
   output logic             DSL,
   output logic [3:0]       Dpar,
   output logic             RegMR_n,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      CLEAR   = 3'd2,
      SHIFT   = 3'd3,
      CAPTURE = 3'd4
   } state_t;

   state_t           state;
   logic [1:0]       cmd_q;
   logic [CNT_W-1:0] count_q;
   logic [3:0]       din_q;
   logic             serin_q;
   logic             rot_q;
   logic [CNT_W-1:0] step_cnt;
   logic             done_q;
   logic [3:0]       dout_q;

   always_ff @(posedge Clk) begin
      if (MR) begin
         state    <= IDLE;
         cmd_q    <= '0;
         count_q  <= '0;
         din_q    <= '0;
         serin_q  <= 1'b0;
         rot_q    <= 1'b0;
         step_cnt <= '0;
         done_q   <= 1'b0;
         dout_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (host.Start) begin
                  cmd_q   <= host.Cmd;
                  count_q <= host.Count;
                  din_q   <= host.Din;
                  serin_q <= host.SerIn;
                  rot_q   <= host.Rot;
                  state   <= (host.Cmd == 2'b11) ? CLEAR : LOAD;
               end
            end
            LOAD: begin
               if (cmd_q == 2'b00 || count_q == '0) begin
                  state <= CAPTURE;
               end else begin
                  step_cnt <= count_q;
                  state    <= SHIFT;
               end
            end
            CLEAR: state <= CAPTURE;
            SHIFT: begin
               // Leaving when the counter reads 1 yields exactly Count shift edges.
               step_cnt <= step_cnt - 1'b1;
               if (step_cnt == CNT_W'(1)) state <= CAPTURE;
            end
            CAPTURE: begin
               dout_q <= Q;
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pin decodes depend only on state and latched regs, never on Start.
   always_comb begin
      S1   = 1'b0;
      S0   = 1'b0;
      Dpar = 4'b0000;
      DSR  = 1'b0;
      DSL  = 1'b0;
      case (state)
         LOAD: begin
            {S1, S0} = 2'b11;
            Dpar     = din_q;
         end
         SHIFT: begin
            {S1, S0} = (cmd_q == 2'b01) ? 2'b01 : 2'b10;
            DSR      = rot_q ? Q[3] : serin_q;
            DSL      = rot_q ? Q[0] : serin_q;
         end
         default: ;
      endcase
   end

   assign RegMR_n   = !MR && (state != CLEAR);
   assign host.Busy = (state != IDLE);
   assign host.Done = done_q;
   assign host.Dout = dout_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_hc194_seq_ctrl.sv
// Directed bench for hc194_seq_ctrl with a behavioural 194 register model
// closing the loop between the mode/data pins and Q.
module tb_hc194_seq_ctrl;

   logic       Clk = 1'b0;
   logic       MR;
   logic [3:0] q_reg;
   logic       S1, S0, DSR, DSL, RegMR_n;
   logic [3:0] Dpar;
   logic [2:0] state_dbg;
   int         checks = 0;
   int         failures = 0;

   always #5 Clk = ~Clk;

   hc194_seq_ctrl_if #(.CNT_W(3)) host_if ();

   hc194_seq_ctrl #(.CNT_W(3)) dut (
      .Clk       (Clk),
      .MR        (MR),
      .host      (host_if.slave),
      .Q         (q_reg),
      .S1        (S1),
      .S0        (S0),
      .DSR       (DSR),
      .DSL       (DSL),
      .Dpar      (Dpar),
      .RegMR_n   (RegMR_n),
      .state_dbg (state_dbg)
   );

   // 194-style register: async active-low clear, S1S0 = hold/right/left/load.
   always_ff @(posedge Clk or negedge RegMR_n) begin
      if (!RegMR_n) q_reg <= 4'b0000;
      else begin
         case ({S1, S0})
            2'b01:   q_reg <= {q_reg[2:0], DSR};
            2'b10:   q_reg <= {DSL, q_reg[3:1]};
            2'b11:   q_reg <= Dpar;
            default: q_reg <= q_reg;
         endcase
      end
   end

   // Drives one command from the current negedge and returns at the Done cycle.
   // lat counts cycles from the Start cycle to Done; -1 means Done never came.
   task automatic run_cmd(input logic [1:0] cmd, input logic [2:0] count,
                          input logic [3:0] din, input logic serin, input logic rot,
                          output int lat, output int shifts, output int clr_cycles);
      logic seen;
      host_if.Cmd   = cmd;
      host_if.Count = count;
      host_if.Din   = din;
      host_if.SerIn = serin;
      host_if.Rot   = rot;
      host_if.Start = 1'b1;
      lat = 0;
      shifts = 0;
      clr_cycles = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         lat++;
         if ({S1, S0} == 2'b01 || {S1, S0} == 2'b10) shifts++;
         if (!RegMR_n) clr_cycles++;
         host_if.Start = 1'b0;
         if (host_if.Done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) lat = -1;
   endtask

   task automatic test_reset();
      MR = 1'b1;
      host_if.Start = 1'b0;
      host_if.Cmd = 2'b00;
      host_if.Count = 3'd0;
      host_if.Din = 4'b0000;
      host_if.SerIn = 1'b0;
      host_if.Rot = 1'b0;
      repeat (2) @(negedge Clk);
      checks++;
      if (RegMR_n !== 1'b0) begin failures++; $display("FAIL reset_regmr got=%b exp=0", RegMR_n); end
      checks++;
      if (host_if.Busy !== 1'b0 || host_if.Done !== 1'b0) begin
         failures++; $display("FAIL reset_busy_done got=%b%b exp=00", host_if.Busy, host_if.Done);
      end
      checks++;
      if (host_if.Dout !== 4'b0000) begin failures++; $display("FAIL reset_dout got=%b exp=0000", host_if.Dout); end
      checks++;
      if ({S1, S0} !== 2'b00 || state_dbg !== 3'd0) begin
         failures++; $display("FAIL reset_mode_state got=%b%b/%0d exp=00/0", S1, S0, state_dbg);
      end
      MR = 1'b0;
      @(negedge Clk);
      checks++;
      if (RegMR_n !== 1'b1 || host_if.Busy !== 1'b0) begin
         failures++; $display("FAIL reset_release got=%b%b exp=10", RegMR_n, host_if.Busy);
      end
   endtask

   task automatic test_load_only();
      host_if.Cmd = 2'b00;
      host_if.Count = 3'd5;
      host_if.Din = 4'b1011;
      host_if.Start = 1'b1;
      @(negedge Clk);
      host_if.Start = 1'b0;
      checks++;
      if ({S1, S0} !== 2'b11 || Dpar !== 4'b1011 || host_if.Busy !== 1'b1) begin
         failures++; $display("FAIL load_cycle got=%b%b/%b/%b exp=11/1011/1", S1, S0, Dpar, host_if.Busy);
      end
      @(negedge Clk);
      checks++;
      if ({S1, S0} !== 2'b00 || host_if.Done !== 1'b0 || Dpar !== 4'b0000) begin
         failures++; $display("FAIL load_capture got=%b%b/%b/%b exp=00/0/0000", S1, S0, host_if.Done, Dpar);
      end
      @(negedge Clk);
      checks++;
      if (host_if.Done !== 1'b1 || host_if.Dout !== 4'b1011 || host_if.Busy !== 1'b0) begin
         failures++; $display("FAIL load_done got=%b/%b/%b exp=1/1011/0", host_if.Done, host_if.Dout, host_if.Busy);
      end
      @(negedge Clk);
      checks++;
      if (host_if.Done !== 1'b0 || host_if.Dout !== 4'b1011) begin
         failures++; $display("FAIL load_hold got=%b/%b exp=0/1011", host_if.Done, host_if.Dout);
      end
   endtask

   task automatic test_shift_cases();
      int lat, shifts, clr;
      run_cmd(2'b01, 3'd1, 4'b1011, 1'b0, 1'b0, lat, shifts, clr);
      checks++;
      if (lat != 4 || shifts != 1 || host_if.Dout !== 4'b0110) begin
         failures++; $display("FAIL shr1 got=lat%0d sh%0d %b exp=lat4 sh1 0110", lat, shifts, host_if.Dout);
      end
      @(negedge Clk);
      run_cmd(2'b10, 3'd1, 4'b1011, 1'b0, 1'b1, lat, shifts, clr);
      checks++;
      if (lat != 4 || host_if.Dout !== 4'b1101) begin
         failures++; $display("FAIL shl_rot got=lat%0d %b exp=lat4 1101", lat, host_if.Dout);
      end
      @(negedge Clk);
      run_cmd(2'b01, 3'd4, 4'b1011, 1'b0, 1'b1, lat, shifts, clr);
      checks++;
      if (lat != 7 || shifts != 4 || host_if.Dout !== 4'b1011) begin
         failures++; $display("FAIL rot4 got=lat%0d sh%0d %b exp=lat7 sh4 1011", lat, shifts, host_if.Dout);
      end
      @(negedge Clk);
      run_cmd(2'b01, 3'd3, 4'b0000, 1'b1, 1'b0, lat, shifts, clr);
      checks++;
      if (lat != 6 || shifts != 3 || host_if.Dout !== 4'b0111) begin
         failures++; $display("FAIL serin_fill got=lat%0d sh%0d %b exp=lat6 sh3 0111", lat, shifts, host_if.Dout);
      end
      @(negedge Clk);
      run_cmd(2'b01, 3'd7, 4'b1001, 1'b1, 1'b0, lat, shifts, clr);
      checks++;
      if (lat != 10 || shifts != 7 || host_if.Dout !== 4'b1111) begin
         failures++; $display("FAIL shr_max got=lat%0d sh%0d %b exp=lat10 sh7 1111", lat, shifts, host_if.Dout);
      end
      @(negedge Clk);
      run_cmd(2'b01, 3'd0, 4'b1100, 1'b1, 1'b0, lat, shifts, clr);
      checks++;
      if (lat != 3 || shifts != 0 || host_if.Dout !== 4'b1100) begin
         failures++; $display("FAIL count_zero got=lat%0d sh%0d %b exp=lat3 sh0 1100", lat, shifts, host_if.Dout);
      end
      @(negedge Clk);
   endtask

   task automatic test_clear();
      int lat, shifts, clr;
      run_cmd(2'b00, 3'd0, 4'b1111, 1'b0, 1'b0, lat, shifts, clr);
      checks++;
      if (lat != 3 || host_if.Dout !== 4'b1111) begin
         failures++; $display("FAIL clear_preload got=lat%0d %b exp=lat3 1111", lat, host_if.Dout);
      end
      @(negedge Clk);
      run_cmd(2'b11, 3'd2, 4'b1010, 1'b1, 1'b0, lat, shifts, clr);
      checks++;
      if (lat != 3 || clr != 1 || shifts != 0 || host_if.Dout !== 4'b0000) begin
         failures++; $display("FAIL clear got=lat%0d clr%0d sh%0d %b exp=lat3 clr1 sh0 0000", lat, clr, shifts, host_if.Dout);
      end
      @(negedge Clk);
   endtask

   task automatic test_back_to_back();
      int n_done, done_at;
      logic [3:0] dout_at_done;
      n_done = 0;
      done_at = -1;
      dout_at_done = 4'bxxxx;
      host_if.Cmd = 2'b01;
      host_if.Count = 3'd3;
      host_if.Din = 4'b0000;
      host_if.SerIn = 1'b1;
      host_if.Rot = 1'b0;
      host_if.Start = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         @(negedge Clk);
         if (host_if.Done) begin
            n_done++;
            done_at = n;
            dout_at_done = host_if.Dout;
         end
         // A second command offered mid-flight must be dropped.
         host_if.Start = (n == 2);
         if (n == 2) begin
            host_if.Cmd = 2'b00;
            host_if.Din = 4'b1111;
         end
      end
      checks++;
      if (n_done != 1 || done_at != 6 || dout_at_done !== 4'b0111) begin
         failures++; $display("FAIL busy_ignore got=n%0d at%0d %b exp=n1 at6 0111", n_done, done_at, dout_at_done);
      end
   endtask

   task automatic test_start_on_done();
      int lat, shifts, clr;
      run_cmd(2'b10, 3'd2, 4'b0001, 1'b1, 1'b0, lat, shifts, clr);
      checks++;
      if (lat != 5 || host_if.Dout !== 4'b1100) begin
         failures++; $display("FAIL shl_fill got=lat%0d %b exp=lat5 1100", lat, host_if.Dout);
      end
      host_if.Cmd = 2'b00;
      host_if.Din = 4'b0101;
      host_if.Start = 1'b1;
      @(negedge Clk);
      host_if.Start = 1'b0;
      checks++;
      if (host_if.Busy !== 1'b1 || {S1, S0} !== 2'b11 || Dpar !== 4'b0101) begin
         failures++; $display("FAIL start_on_done got=%b/%b%b/%b exp=1/11/0101", host_if.Busy, S1, S0, Dpar);
      end
      repeat (2) @(negedge Clk);
      checks++;
      if (host_if.Done !== 1'b1 || host_if.Dout !== 4'b0101) begin
         failures++; $display("FAIL start_on_done_result got=%b/%b exp=1/0101", host_if.Done, host_if.Dout);
      end
      @(negedge Clk);
   endtask

   task automatic test_mid_shift_reset();
      int n_done;
      n_done = 0;
      host_if.Cmd = 2'b01;
      host_if.Count = 3'd7;
      host_if.Din = 4'b1011;
      host_if.SerIn = 1'b0;
      host_if.Rot = 1'b0;
      host_if.Start = 1'b1;
      @(negedge Clk);
      host_if.Start = 1'b0;
      repeat (2) @(negedge Clk);
      checks++;
      if ({S1, S0} !== 2'b01 || host_if.Busy !== 1'b1) begin
         failures++; $display("FAIL mr_pre_shift got=%b%b/%b exp=01/1", S1, S0, host_if.Busy);
      end
      MR = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         checks++;
         if (RegMR_n !== 1'b0) begin failures++; $display("FAIL mr_regmr got=%b exp=0", RegMR_n); end
      end
      MR = 1'b0;
      @(negedge Clk);
      checks++;
      if (state_dbg !== 3'd0 || host_if.Busy !== 1'b0 || host_if.Dout !== 4'b0000 || {S1, S0} !== 2'b00) begin
         failures++; $display("FAIL mr_after got=st%0d b%b %b %b%b exp=st0 b0 0000 00",
                              state_dbg, host_if.Busy, host_if.Dout, S1, S0);
      end
      checks++;
      if (q_reg !== 4'b0000 || RegMR_n !== 1'b1) begin
         failures++; $display("FAIL mr_reg_cleared got=%b/%b exp=0000/1", q_reg, RegMR_n);
      end
      for (int i = 0; i < 12; i++) begin
         if (host_if.Done) n_done++;
         @(negedge Clk);
      end
      checks++;
      if (n_done != 0) begin failures++; $display("FAIL mr_no_done got=%0d exp=0", n_done); end
   endtask

   initial begin
      @(negedge Clk);
      test_reset();
      test_load_only();
      test_shift_cases();
      test_clear();
      test_back_to_back();
      test_start_on_done();
      test_mid_shift_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
